// File: rtl/cache_controller_4way_pkg.sv
// Shared widths, entry layout and FSM encodings for the 4-way cache controller.
package cache_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int BLOCK_OFFSET     = 4;
  localparam int SETS             = 128;
  localparam int SETS_BITS        = 7;
  localparam int AGE_BITS         = 2;
  localparam int TAG_BITS         = WORD_SIZE - SETS_BITS - BLOCK_OFFSET;
  localparam int BLOCK_DATA_WIDTH = 512;
  localparam int DIRTY_BIT        = 1;
  localparam int VALID_BIT        = 1;
  localparam int BANK             = 4;

  localparam int ENTRY_WIDTH = VALID_BIT + DIRTY_BIT + AGE_BITS + TAG_BITS + BLOCK_DATA_WIDTH;

  // Field offsets inside one way entry {valid, dirty, age, tag, data}
  localparam int DATA_LSB  = 0;
  localparam int TAG_LSB   = BLOCK_DATA_WIDTH;
  localparam int AGE_LSB   = TAG_LSB + TAG_BITS;
  localparam int DIRTY_POS = AGE_LSB + AGE_BITS;
  localparam int VALID_POS = DIRTY_POS + DIRTY_BIT;

  typedef struct packed {
    logic                        valid;
    logic                        dirty;
    logic [AGE_BITS-1:0]         age;
    logic [TAG_BITS-1:0]         tag;
    logic [BLOCK_DATA_WIDTH-1:0] data;
  } entry_t;

  // Controller states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_ALLOCATE  = 3'd3;
  localparam logic [2:0] ST_UPDATE    = 3'd4;

  // Way index to one-hot bank select (bit0 = way 1)
  function automatic logic [BANK-1:0] way_onehot(input logic [1:0] way);
    return 4'b0001 << way;
  endfunction

endpackage

// File: rtl/cache_controller_4way_if.sv
// CPU, memory and cache-array signal bundle of the cache controller.
// Handshakes: the CPU request is a strobe taken only while idle and answered
// by a one-cycle cpu_res_ready pulse; mem_req_enable is held with stable
// addr/rw/data until the cycle mem_req_ready is seen high at a clock edge;
// cache_ready marks the cycle the four candidates are valid during lookup.
interface cache_controller_4way_if;
  import cache_pkg::*;

  logic [WORD_SIZE-1:0]        cpu_req_addr;
  logic [WORD_SIZE-1:0]        cpu_req_datain;
  logic                        cpu_req_rw;
  logic                        cpu_req_enable;
  logic [WORD_SIZE-1:0]        cpu_res_dataout;
  logic                        cpu_res_ready;

  logic [WORD_SIZE-1:0]        mem_req_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
  logic                        mem_req_rw;
  logic                        mem_req_enable;
  logic                        mem_req_ready;

  logic                        cache_enable;
  logic                        cache_rw;
  logic                        cache_ready;
  logic [SETS_BITS-1:0]        cache_index;
  logic [ENTRY_WIDTH-1:0]      candidate_1;
  logic [ENTRY_WIDTH-1:0]      candidate_2;
  logic [ENTRY_WIDTH-1:0]      candidate_3;
  logic [ENTRY_WIDTH-1:0]      candidate_4;
  logic [AGE_BITS-1:0]         age_1;
  logic [AGE_BITS-1:0]         age_2;
  logic [AGE_BITS-1:0]         age_3;
  logic [AGE_BITS-1:0]         age_4;
  logic [ENTRY_WIDTH-1:0]      candidate_write;
  logic [BANK-1:0]             bank_selector;

  modport master (
    input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_enable,
    output cpu_res_dataout, cpu_res_ready,
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_enable,
    input  mem_req_datain, mem_req_ready,
    output cache_enable, cache_rw, cache_index,
    input  cache_ready, candidate_1, candidate_2, candidate_3, candidate_4,
    output age_1, age_2, age_3, age_4, candidate_write, bank_selector
  );

  modport slave (
    output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_enable,
    input  cpu_res_dataout, cpu_res_ready,
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_enable,
    output mem_req_datain, mem_req_ready,
    input  cache_enable, cache_rw, cache_index,
    output cache_ready, candidate_1, candidate_2, candidate_3, candidate_4,
    input  age_1, age_2, age_3, age_4, candidate_write, bank_selector
  );

endinterface

// File: rtl/cache_controller_4way_lru_victim_select.sv
// Hit detection, victim choice and age update for one 4-way set.
module lru_victim_select
  import cache_pkg::*;
(
  input  logic [BANK-1:0]                valid,
  input  logic [BANK-1:0][AGE_BITS-1:0]  age,
  input  logic [BANK-1:0][TAG_BITS-1:0]  tag,
  input  logic [TAG_BITS-1:0]            req_tag,
  output logic [BANK-1:0]                hit_vec,
  output logic [1:0]                     sel_way,
  output logic [BANK-1:0][AGE_BITS-1:0]  new_age
);

  logic                          hit_found;
  logic [1:0]                    hit_way;
  logic                          inv_found;
  logic [1:0]                    inv_way;
  logic [1:0]                    max_way;
  logic [AGE_BITS-1:0]           old_age;
  logic [BANK-1:0][AGE_BITS-1:0] eff_age;

  // Lowest hit wins; otherwise lowest invalid, else oldest (lowest on ties).
  // A refilled or invalid way is treated as age 3 for the age update.
  always_comb begin
    hit_vec   = '0;
    hit_found = 1'b0;
    hit_way   = 2'd0;
    inv_found = 1'b0;
    inv_way   = 2'd0;
    max_way   = 2'd0;
    eff_age   = '0;
    new_age   = '0;
    for (int i = 0; i < BANK; i++) begin
      hit_vec[i] = valid[i] && (tag[i] == req_tag);
      eff_age[i] = valid[i] ? age[i] : 2'd3;
      if (hit_vec[i] && !hit_found) begin
        hit_found = 1'b1;
        hit_way   = 2'(i);
      end
      if (!valid[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = 2'(i);
      end
    end
    for (int i = 1; i < BANK; i++) begin
      if (age[i] > age[max_way]) max_way = 2'(i);
    end
    if (hit_found) sel_way = hit_way;
    else if (inv_found) sel_way = inv_way;
    else sel_way = max_way;
    old_age = hit_found ? age[hit_way] : 2'd3;
    for (int i = 0; i < BANK; i++) begin
      if (2'(i) == sel_way) new_age[i] = 2'd0;
      else if (eff_age[i] < old_age) new_age[i] = eff_age[i] + 2'd1;
      else new_age[i] = eff_age[i];
    end
  end

endmodule

// File: rtl/cache_controller_4way.sv
// 4-way write-back, write-allocate cache controller: lookup, dirty
// writeback, refill and word merge, with age-based LRU replacement.
module cache_controller_4way
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  cache_controller_4way_if.master bus,
  output logic [2:0]             current_state,
  output logic                   hit,
  output logic                   miss
);

  logic [2:0]                    state;
  logic [WORD_SIZE-1:0]          addr_q;
  logic                          rw_q;
  logic [WORD_SIZE-1:0]          datain_q;
  logic [1:0]                    way_q;
  logic                          hit_q;
  logic                          dirty_q;
  logic [TAG_BITS-1:0]           tag_q;
  logic [BLOCK_DATA_WIDTH-1:0]   data_q;
  logic [BANK-1:0][AGE_BITS-1:0] age_q;

  entry_t [BANK-1:0]             cand;
  logic [BANK-1:0]               cand_valid;
  logic [BANK-1:0][AGE_BITS-1:0] cand_age;
  logic [BANK-1:0][TAG_BITS-1:0] cand_tag;
  logic [BANK-1:0]               hit_vec;
  logic                          hit_any;
  logic [1:0]                    sel_way;
  logic [BANK-1:0][AGE_BITS-1:0] new_age;
  logic [BLOCK_DATA_WIDTH-1:0]   merged;
  logic                          dirty_new;

  assign cand[0] = bus.candidate_1;
  assign cand[1] = bus.candidate_2;
  assign cand[2] = bus.candidate_3;
  assign cand[3] = bus.candidate_4;

  // Split the candidates into the fields the replacement logic needs
  always_comb begin
    cand_valid = '0;
    cand_age   = '0;
    cand_tag   = '0;
    for (int i = 0; i < BANK; i++) begin
      cand_valid[i] = cand[i].valid;
      cand_age[i]   = cand[i].age;
      cand_tag[i]   = cand[i].tag;
    end
  end

  lru_victim_select u_lru (
    .valid   (cand_valid),
    .age     (cand_age),
    .tag     (cand_tag),
    .req_tag (addr_q[WORD_SIZE-1 -: TAG_BITS]),
    .hit_vec (hit_vec),
    .sel_way (sel_way),
    .new_age (new_age)
  );

  assign hit_any       = |hit_vec;
  assign current_state = state;
  assign hit           = (state == ST_LOOKUP) && bus.cache_ready && hit_any;
  assign miss          = (state == ST_LOOKUP) && bus.cache_ready && !hit_any;

  // FSM and latched request / selected-way context
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      datain_q <= '0;
      way_q    <= 2'd0;
      hit_q    <= 1'b0;
      dirty_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      age_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req_enable) begin
            addr_q   <= bus.cpu_req_addr;
            rw_q     <= bus.cpu_req_rw;
            datain_q <= bus.cpu_req_datain;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (bus.cache_ready) begin
            way_q   <= sel_way;
            hit_q   <= hit_any;
            dirty_q <= cand[sel_way].dirty;
            tag_q   <= cand[sel_way].tag;
            data_q  <= cand[sel_way].data;
            age_q   <= new_age;
            if (hit_any) state <= ST_UPDATE;
            else if (cand[sel_way].valid && cand[sel_way].dirty) state <= ST_WRITEBACK;
            else state <= ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_req_ready) state <= ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          if (bus.mem_req_ready) begin
            data_q <= bus.mem_req_datain;
            state  <= ST_UPDATE;
          end
        end
        ST_UPDATE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Merge the CPU write word into the block and pick the new dirty bit
  always_comb begin
    merged = data_q;
    if (rw_q) merged[{addr_q[BLOCK_OFFSET-1:0], 5'd0} +: WORD_SIZE] = datain_q;
    dirty_new = rw_q ? 1'b1 : (hit_q ? dirty_q : 1'b0);
  end

  // State-decoded outputs; everything is zero while idle
  always_comb begin
    bus.cpu_res_dataout = '0;
    bus.cpu_res_ready   = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_dataout = '0;
    bus.mem_req_rw      = 1'b0;
    bus.mem_req_enable  = 1'b0;
    bus.cache_enable    = (state != ST_IDLE);
    bus.cache_rw        = 1'b0;
    bus.cache_index     = addr_q[BLOCK_OFFSET +: SETS_BITS];
    bus.age_1           = '0;
    bus.age_2           = '0;
    bus.age_3           = '0;
    bus.age_4           = '0;
    bus.candidate_write = '0;
    bus.bank_selector   = '0;
    case (state)
      ST_WRITEBACK: begin
        bus.mem_req_enable  = 1'b1;
        bus.mem_req_rw      = 1'b1;
        bus.mem_req_addr    = {tag_q, addr_q[BLOCK_OFFSET +: SETS_BITS], 4'b0000};
        bus.mem_req_dataout = data_q;
      end
      ST_ALLOCATE: begin
        bus.mem_req_enable = 1'b1;
        bus.mem_req_addr   = {addr_q[WORD_SIZE-1:BLOCK_OFFSET], 4'b0000};
      end
      ST_UPDATE: begin
        bus.cache_rw        = 1'b1;
        bus.bank_selector   = way_onehot(way_q);
        bus.candidate_write = {1'b1, dirty_new, 2'b00, addr_q[WORD_SIZE-1 -: TAG_BITS], merged};
        bus.age_1           = age_q[0];
        bus.age_2           = age_q[1];
        bus.age_3           = age_q[2];
        bus.age_4           = age_q[3];
        bus.cpu_res_dataout = merged[{addr_q[BLOCK_OFFSET-1:0], 5'd0} +: WORD_SIZE];
        bus.cpu_res_ready   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_controller_4way.sv
// Directed bench for cache_controller_4way. Address 0x00000ABC decodes as
// tag=1, set=0x2B, word=0xC; 0x00000AB4 -> word 4, 0x00000ABD -> word 13.
module tb_cache_controller_4way;
  import cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] current_state;
  logic       hit;
  logic       miss;
  int         checks = 0;
  int         errors = 0;

  logic [536:0] cw;
  logic [511:0] wb;
  logic [511:0] blk;
  logic [536:0] tmp;
  int           lat;

  cache_controller_4way_if bus ();

  cache_controller_4way dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .current_state (current_state),
    .hit           (hit),
    .miss          (miss)
  );

  // clock
  always #5 clk = ~clk;

  // hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [536:0] mk(input logic v, input logic d, input logic [1:0] a,
                                      input logic [20:0] t, input logic [31:0] base);
    logic [536:0] e;
    e = {v, d, a, t, 512'd0};
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = base + 32'(i);
    return e;
  endfunction

  task automatic set_cands(input logic [536:0] c1, input logic [536:0] c2,
                           input logic [536:0] c3, input logic [536:0] c4);
    bus.candidate_1 = c1;
    bus.candidate_2 = c2;
    bus.candidate_3 = c3;
    bus.candidate_4 = c4;
  endtask

  // Issue a request, present candidates for one cycle, check the lookup cycle
  task automatic do_lookup(input logic [31:0] addr, input logic rw, input logic [31:0] data,
                           input logic exp_hit, input string tag);
    @(negedge clk);
    bus.cpu_req_addr   = addr;
    bus.cpu_req_rw     = rw;
    bus.cpu_req_datain = data;
    bus.cpu_req_enable = 1'b1;
    @(negedge clk);
    bus.cpu_req_enable = 1'b0;
    bus.cache_ready    = 1'b1;
    #1;
    chk({tag, "_state_lookup"}, 32'(current_state), 32'(ST_LOOKUP));
    chk({tag, "_cache_en"}, 32'(bus.cache_enable), 32'd1);
    chk({tag, "_cache_rw0"}, 32'(bus.cache_rw), 32'd0);
    chk({tag, "_index"}, 32'(bus.cache_index), 32'(addr[10:4]));
    chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    chk({tag, "_miss"}, 32'(miss), 32'(!exp_hit));
    @(negedge clk);
    bus.cache_ready = 1'b0;
  endtask

  // Serve one memory request with a bounded wait
  task automatic mem_phase(input logic exp_rw, input logic [31:0] exp_addr,
                           input logic [511:0] refill, output logic [511:0] wbd, input string tag);
    int n = 0;
    while (!bus.mem_req_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_mem_en"}, 32'(bus.mem_req_enable), 32'd1);
    chk({tag, "_mem_rw"}, 32'(bus.mem_req_rw), 32'(exp_rw));
    chk({tag, "_mem_addr"}, bus.mem_req_addr, exp_addr);
    wbd = bus.mem_req_dataout;
    bus.mem_req_datain = refill;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
  endtask

  // Wait (bounded) for the response pulse; leaves time at that negedge
  task automatic wait_resp(output int n, input string tag);
    n = 0;
    while (!bus.cpu_res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_res_ready"}, 32'(bus.cpu_res_ready), 32'd1);
    chk({tag, "_cache_rw1"}, 32'(bus.cache_rw), 32'd1);
  endtask

  // One cycle later the pulse is gone and the controller is idle
  task automatic resp_done(input string tag);
    @(negedge clk);
    chk({tag, "_res_pulse"}, 32'(bus.cpu_res_ready), 32'd0);
    chk({tag, "_cache_en_off"}, 32'(bus.cache_enable), 32'd0);
    chk({tag, "_idle"}, 32'(current_state), 32'(ST_IDLE));
  endtask

  initial begin
    bus.cpu_req_addr   = '0;
    bus.cpu_req_datain = '0;
    bus.cpu_req_rw     = 1'b0;
    bus.cpu_req_enable = 1'b0;
    bus.mem_req_datain = '0;
    bus.mem_req_ready  = 1'b0;
    bus.cache_ready    = 1'b0;
    set_cands('0, '0, '0, '0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(current_state), 32'(ST_IDLE));
    chk("rst_cache_en", 32'(bus.cache_enable), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_req_enable), 32'd0);
    chk("rst_res_ready", 32'(bus.cpu_res_ready), 32'd0);
    chk("rst_bank", 32'(bus.bank_selector), 32'd0);
    chk("rst_index", 32'(bus.cache_index), 32'd0);
    rst_n = 1'b0;

    // T1 read hit: all four ways hit, way1 wins; ages 2,0,1,3 -> 0,1,2,3
    set_cands(mk(1, 0, 2, 1, 32'hDEADBEEF), mk(1, 0, 0, 1, 32'hDEADBEEF),
              mk(1, 0, 1, 1, 32'hDEADBEEF), mk(1, 0, 3, 1, 32'hDEADBEEF));
    do_lookup(32'h00000ABC, 1'b0, 32'd0, 1'b1, "t1");
    wait_resp(lat, "t1");
    chk("t1_latency", 32'(lat), 32'd0);
    chk("t1_no_mem", 32'(bus.mem_req_enable), 32'd0);
    chk("t1_data", bus.cpu_res_dataout, 32'hDEADBEFB);
    chk("t1_bank", 32'(bus.bank_selector), 32'b0001);
    cw = bus.candidate_write;
    chk("t1_valid", 32'(cw[536]), 32'd1);
    chk("t1_dirty", 32'(cw[535]), 32'd0);
    chk("t1_age_field", 32'(cw[534:533]), 32'd0);
    chk("t1_tag", 32'(cw[532:512]), 32'd1);
    chk("t1_word12", cw[12*32 +: 32], 32'hDEADBEFB);
    chk("t1_age1", 32'(bus.age_1), 32'd0);
    chk("t1_age2", 32'(bus.age_2), 32'd1);
    chk("t1_age3", 32'(bus.age_3), 32'd2);
    chk("t1_age4", 32'(bus.age_4), 32'd3);
    resp_done("t1");

    // T2 clean miss: way1 invalid (tag matches but invalid), others tag 2
    set_cands(mk(0, 0, 0, 1, 32'h0), mk(1, 0, 0, 2, 32'h01000000),
              mk(1, 0, 1, 2, 32'h02000000), mk(1, 0, 2, 2, 32'h03000000));
    do_lookup(32'h00000ABC, 1'b0, 32'd0, 1'b0, "t2");
    tmp = mk(1, 0, 0, 0, 32'hDEADBEEF);
    blk = tmp[511:0];
    mem_phase(1'b0, 32'h00000AB0, blk, wb, "t2_alloc");
    wait_resp(lat, "t2");
    chk("t2_data", bus.cpu_res_dataout, 32'hDEADBEFB);
    chk("t2_bank", 32'(bus.bank_selector), 32'b0001);
    cw = bus.candidate_write;
    chk("t2_valid", 32'(cw[536]), 32'd1);
    chk("t2_dirty", 32'(cw[535]), 32'd0);
    chk("t2_tag", 32'(cw[532:512]), 32'd1);
    chk("t2_word0", cw[31:0], 32'hDEADBEEF);
    chk("t2_age1", 32'(bus.age_1), 32'd0);
    chk("t2_age2", 32'(bus.age_2), 32'd1);
    chk("t2_age3", 32'(bus.age_3), 32'd2);
    chk("t2_age4", 32'(bus.age_4), 32'd3);
    resp_done("t2");

    // T3 dirty eviction: tag 5 everywhere, ages 3,2,1,0 -> victim way1
    set_cands(mk(1, 1, 3, 5, 32'h11110000), mk(1, 1, 2, 5, 32'h22220000),
              mk(1, 1, 1, 5, 32'h33330000), mk(1, 1, 0, 5, 32'h44440000));
    do_lookup(32'h00000ABC, 1'b0, 32'd0, 1'b0, "t3");
    mem_phase(1'b1, 32'h00002AB0, '0, wb, "t3_wb");
    chk("t3_wb_word0", wb[31:0], 32'h11110000);
    chk("t3_wb_word15", wb[511:480], 32'h1111000F);
    tmp = mk(1, 0, 0, 0, 32'h77770000);
    blk = tmp[511:0];
    mem_phase(1'b0, 32'h00000AB0, blk, wb, "t3_alloc");
    wait_resp(lat, "t3");
    chk("t3_data", bus.cpu_res_dataout, 32'h7777000C);
    chk("t3_bank", 32'(bus.bank_selector), 32'b0001);
    cw = bus.candidate_write;
    chk("t3_dirty", 32'(cw[535]), 32'd0);
    chk("t3_age1", 32'(bus.age_1), 32'd0);
    chk("t3_age2", 32'(bus.age_2), 32'd3);
    chk("t3_age3", 32'(bus.age_3), 32'd2);
    chk("t3_age4", 32'(bus.age_4), 32'd1);
    resp_done("t3");

    // T3b age tie: ages 1,3,3,0 all clean -> victim way2, ages 2,0,3,1
    set_cands(mk(1, 0, 1, 5, 32'h0), mk(1, 0, 3, 5, 32'h0),
              mk(1, 0, 3, 5, 32'h0), mk(1, 0, 0, 5, 32'h0));
    do_lookup(32'h00000ABC, 1'b0, 32'd0, 1'b0, "t3b");
    tmp = mk(1, 0, 0, 0, 32'h44440000);
    blk = tmp[511:0];
    mem_phase(1'b0, 32'h00000AB0, blk, wb, "t3b_alloc");
    wait_resp(lat, "t3b");
    chk("t3b_data", bus.cpu_res_dataout, 32'h4444000C);
    chk("t3b_bank", 32'(bus.bank_selector), 32'b0010);
    chk("t3b_age1", 32'(bus.age_1), 32'd2);
    chk("t3b_age2", 32'(bus.age_2), 32'd0);
    chk("t3b_age3", 32'(bus.age_3), 32'd3);
    chk("t3b_age4", 32'(bus.age_4), 32'd1);
    resp_done("t3b");

    // T4 write hit: only way3 holds tag 1; ages 0,1,2,3 -> 1,2,0,3
    set_cands(mk(1, 0, 0, 2, 32'hDEADBEEF), mk(1, 0, 1, 2, 32'hDEADBEEF),
              mk(1, 0, 2, 1, 32'hDEADBEEF), mk(1, 0, 3, 2, 32'hDEADBEEF));
    do_lookup(32'h00000AB4, 1'b1, 32'hCAFEBABE, 1'b1, "t4");
    wait_resp(lat, "t4");
    chk("t4_latency", 32'(lat), 32'd0);
    chk("t4_no_mem", 32'(bus.mem_req_enable), 32'd0);
    chk("t4_data", bus.cpu_res_dataout, 32'hCAFEBABE);
    chk("t4_bank", 32'(bus.bank_selector), 32'b0100);
    cw = bus.candidate_write;
    chk("t4_word4", cw[4*32 +: 32], 32'hCAFEBABE);
    chk("t4_word5", cw[5*32 +: 32], 32'hDEADBEF4);
    chk("t4_dirty", 32'(cw[535]), 32'd1);
    chk("t4_age1", 32'(bus.age_1), 32'd1);
    chk("t4_age2", 32'(bus.age_2), 32'd2);
    chk("t4_age3", 32'(bus.age_3), 32'd0);
    chk("t4_age4", 32'(bus.age_4), 32'd3);
    resp_done("t4");

    // T5 write miss: ways 1-2 invalid -> refill into way1, word13 written
    set_cands(mk(0, 0, 0, 1, 32'h0), mk(0, 0, 0, 1, 32'h0),
              mk(1, 1, 0, 2, 32'h55550000), mk(1, 1, 1, 2, 32'h66660000));
    do_lookup(32'h00000ABD, 1'b1, 32'hFACECAFE, 1'b0, "t5");
    tmp = mk(1, 0, 0, 0, 32'h33330000);
    blk = tmp[511:0];
    mem_phase(1'b0, 32'h00000AB0, blk, wb, "t5_alloc");
    wait_resp(lat, "t5");
    chk("t5_data", bus.cpu_res_dataout, 32'hFACECAFE);
    chk("t5_bank", 32'(bus.bank_selector), 32'b0001);
    cw = bus.candidate_write;
    chk("t5_word13", cw[13*32 +: 32], 32'hFACECAFE);
    chk("t5_word12", cw[12*32 +: 32], 32'h3333000C);
    chk("t5_valid", 32'(cw[536]), 32'd1);
    chk("t5_dirty", 32'(cw[535]), 32'd1);
    chk("t5_age1", 32'(bus.age_1), 32'd0);
    chk("t5_age3", 32'(bus.age_3), 32'd1);
    chk("t5_age4", 32'(bus.age_4), 32'd2);
    resp_done("t5");

    // T6 reset while waiting for a refill
    set_cands(mk(0, 0, 0, 1, 32'h0), mk(1, 0, 0, 2, 32'h0),
              mk(1, 0, 1, 2, 32'h0), mk(1, 0, 2, 2, 32'h0));
    do_lookup(32'h00000ABC, 1'b0, 32'd0, 1'b0, "t6");
    chk("t6_alloc_state", 32'(current_state), 32'(ST_ALLOCATE));
    chk("t6_mem_en", 32'(bus.mem_req_enable), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_state", 32'(current_state), 32'(ST_IDLE));
    chk("t6_mem_en_off", 32'(bus.mem_req_enable), 32'd0);
    chk("t6_mem_addr", bus.mem_req_addr, 32'd0);
    chk("t6_cache_en", 32'(bus.cache_enable), 32'd0);
    chk("t6_res_ready", 32'(bus.cpu_res_ready), 32'd0);
    chk("t6_index", 32'(bus.cache_index), 32'd0);
    chk("t6_bank", 32'(bus.bank_selector), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
